// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M multiply/divide unit.
// Iterative shift-add multiply and radix-2 restoring divide, one bit per cycle,
// with sign correction in a final FIX cycle. Divide-by-zero and signed overflow
// complete on a single-cycle fast path.
// Optional build macro MULDIV_FAST_MUL_EN: all multiplies complete on the fast
// path through a single-cycle signed multiplier.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  rd,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  wb_rd,
  output logic        wb_we
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [2:0]  r_op;
  logic [31:0] r_hi;      // multiply: product high half; divide: partial remainder
  logic [31:0] r_lo;      // multiply: multiplier / product low half; divide: dividend -> quotient
  logic [31:0] r_d;       // multiplicand or divisor magnitude
  logic        r_neg_a;
  logic        r_neg_b;
  logic [31:0] r_result;
  logic [4:0]  r_wb_rd;
  logic        r_done;
  logic        r_wb_we;

  // Operand classification of the incoming request
  logic        w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [31:0] w_a_mag, w_b_mag;
  logic        w_div0, w_ovf, w_fast_mul, w_fast;
  logic [31:0] w_fast_res;

  assign w_a_signed = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
  assign w_b_signed = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
  assign w_a_neg    = w_a_signed & a[31];
  assign w_b_neg    = w_b_signed & b[31];
  assign w_a_mag    = w_a_neg ? -a : a;
  assign w_b_mag    = w_b_neg ? -b : b;
  assign w_div0     = op[2] && (b == '0);
  assign w_ovf      = ((op == 3'd4) || (op == 3'd6)) &&
                      (a == 32'h8000_0000) && (b == '1);

`ifdef MULDIV_FAST_MUL_EN
  // 64-bit sign/zero-extended operands give the same low 64 product bits as a 33x33 signed multiply
  logic [63:0] w_ax, w_bx, w_prod;
  assign w_ax       = {{32{w_a_signed & a[31]}}, a};
  assign w_bx       = {{32{w_b_signed & b[31]}}, b};
  assign w_prod     = w_ax * w_bx;
  assign w_fast_mul = ~op[2];
`else
  assign w_fast_mul = 1'b0;
`endif

  assign w_fast = w_div0 | w_ovf | w_fast_mul;

  // Fast-path result selection
  always_comb begin
    w_fast_res = '0;
    if (w_div0)      w_fast_res = op[1] ? a : '1;
    else if (w_ovf)  w_fast_res = op[1] ? '0 : 32'h8000_0000;
`ifdef MULDIV_FAST_MUL_EN
    else             w_fast_res = (op == 3'd0) ? w_prod[31:0] : w_prod[63:32];
`endif
  end

  // One iteration step for both datapaths
  logic [32:0] w_shift, w_trial, w_sum;
  logic        w_ge;
  logic [31:0] w_div_hi, w_div_lo, w_mul_hi, w_mul_lo;

  assign w_shift  = {r_hi, r_lo[31]};
  assign w_trial  = w_shift - {1'b0, r_d};
  assign w_ge     = ~w_trial[32];
  assign w_div_hi = w_ge ? w_trial[31:0] : w_shift[31:0];
  assign w_div_lo = {r_lo[30:0], w_ge};
  assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_d} : 33'd0);
  assign w_mul_hi = w_sum[32:1];
  assign w_mul_lo = {w_sum[0], r_lo[31:1]};

  // Sign correction applied in FIX
  logic [63:0] w_prod_fix;
  logic [31:0] w_quo_fix, w_rem_fix, w_fix_res;

  assign w_prod_fix = (r_neg_a ^ r_neg_b) ? -{r_hi, r_lo} : {r_hi, r_lo};
  assign w_quo_fix  = (r_neg_a ^ r_neg_b) ? -r_lo : r_lo;
  assign w_rem_fix  = r_neg_a ? -r_hi : r_hi;

  // Final result selection by captured op
  always_comb begin
    w_fix_res = '0;
    case (r_op)
      3'd0:       w_fix_res = w_prod_fix[31:0];
      3'd1, 3'd2,
      3'd3:       w_fix_res = w_prod_fix[63:32];
      3'd4, 3'd5: w_fix_res = w_quo_fix;
      default:    w_fix_res = w_rem_fix;
    endcase
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_d      <= '0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_result <= '0;
      r_wb_rd  <= '0;
      r_done   <= 1'b0;
      r_wb_we  <= 1'b0;
    end else if (flush) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
      r_wb_we <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done  <= 1'b0;
          r_wb_we <= 1'b0;
          if (start) begin
            r_op    <= op;
            r_wb_rd <= rd;
            r_cnt   <= '0;
            r_neg_a <= w_a_neg;
            r_neg_b <= w_b_neg;
            r_hi    <= '0;
            r_lo    <= op[2] ? w_a_mag : w_b_mag;
            r_d     <= op[2] ? w_b_mag : w_a_mag;
            if (w_fast) begin
              r_result <= w_fast_res;
              r_done   <= 1'b1;
              r_wb_we  <= (rd != '0);
              r_state  <= DONE;
            end else begin
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_hi  <= r_op[2] ? w_div_hi : w_mul_hi;
          r_lo  <= r_op[2] ? w_div_lo : w_mul_lo;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= FIX;
        end
        FIX: begin
          r_result <= w_fix_res;
          r_done   <= 1'b1;
          r_wb_we  <= (r_wb_rd != '0);
          r_state  <= DONE;
        end
        default: begin
          r_done  <= 1'b0;
          r_wb_we <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy   = (r_state != IDLE);
  assign done   = r_done;
  assign result = r_result;
  assign wb_rd  = r_wb_rd;
  assign wb_we  = r_wb_we;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit with directed vectors.
// Honors MULDIV_FAST_MUL_EN for expected multiply latency.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [4:0]  rd = '0;
  logic        busy, done, wb_we;
  logic [31:0] result;
  logic [4:0]  wb_rd;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit MF = 1'b1;
`else
  localparam bit MF = 1'b0;
`endif

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .rd(rd),
    .flush(flush), .busy(busy), .done(done), .result(result),
    .wb_rd(wb_rd), .wb_we(wb_we)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
    int          at;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse pops one expectation
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 want done=0 (cycle %0d, result %h)", cyc, result);
      end else begin
        e = q.pop_front();
        chk("result",  result, e.res);
        chk("wb_rd",   {27'd0, wb_rd}, {27'd0, e.rd});
        chk("wb_we",   {31'd0, wb_we}, {31'd0, e.we});
        chk("latency", cyc, e.at);
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] r, input logic [31:0] er, input bit fast, input bit poke);
    int t;
    exp_t e;
    @(negedge clk);
    op = o; a = x; b = y; rd = r; start = 1'b1;
    t = cyc;
    e.res = er; e.rd = r; e.we = (r != 5'd0); e.at = t + (fast ? 1 : 34);
    q.push_back(e);
    @(negedge clk);
    start = 1'b0; op = 3'd5; a = 32'hDEAD_BEEF; b = 32'h1234_5678; rd = 5'd31;
    for (int i = 0; i < 60 && q.size() != 0; i++) begin
      @(negedge clk);
      if (poke && cyc == t + 5) begin
        start = 1'b1; op = 3'd4; a = 32'd100; b = 32'd3; rd = 5'd3;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout: got no done want done (op %0d, cycle %0d)", o, cyc);
      q.delete();
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int t;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy",   {31'd0, busy},  32'd0);
    chk("rst_done",   {31'd0, done},  32'd0);
    chk("rst_wb_we",  {31'd0, wb_we}, 32'd0);
    chk("rst_result", result,         32'd0);
    chk("rst_wb_rd",  {27'd0, wb_rd}, 32'd0);

    // op, a, b, rd, expected, fast, poke
    issue(3'd4, 32'hFFFF_FFF9, 32'd2,          5'd5,  32'hFFFF_FFFD, 1'b0, 1'b0); // DIV -7/2
    issue(3'd6, 32'hFFFF_FFF9, 32'd2,          5'd6,  32'hFFFF_FFFF, 1'b0, 1'b0); // REM -7/2
    issue(3'd7, 32'd7,         32'd0,          5'd7,  32'd7,         1'b1, 1'b0); // REMU 7/0
    issue(3'd5, 32'd7,         32'd0,          5'd8,  32'hFFFF_FFFF, 1'b1, 1'b0); // DIVU 7/0
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF,  5'd9,  32'h8000_0000, 1'b1, 1'b0); // DIV ovf
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF,  5'd10, 32'd0,         1'b1, 1'b0); // REM ovf
    issue(3'd1, 32'h8000_0000, 32'h8000_0000,  5'd11, 32'h4000_0000, MF,   1'b0); // MULH
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  5'd12, 32'hFFFF_FFFE, MF,   1'b0); // MULHU
    issue(3'd0, 32'd3,         32'd4,          5'd0,  32'd12,        MF,   !MF);  // MUL rd=0, ignored start
    chk("mul_hold_result", result, 32'd12);
    chk("mul_hold_wb_rd",  {27'd0, wb_rd}, 32'd0);
    issue(3'd2, 32'hFFFF_FFFF, 32'd2,          5'd13, 32'hFFFF_FFFF, MF,   1'b0); // MULHSU -1*2
    issue(3'd0, 32'hFFFF_FFFD, 32'd5,          5'd14, 32'hFFFF_FFF1, MF,   1'b0); // MUL -3*5
    issue(3'd5, 32'd100,       32'd3,          5'd15, 32'd33,        1'b0, 1'b0); // DIVU
    issue(3'd7, 32'd100,       32'd3,          5'd16, 32'd1,         1'b0, 1'b0); // REMU
    issue(3'd4, 32'd100,       32'hFFFF_FFF9,  5'd17, 32'hFFFF_FFF2, 1'b0, 1'b0); // DIV 100/-7
    issue(3'd6, 32'd100,       32'hFFFF_FFF9,  5'd18, 32'd2,         1'b0, 1'b0); // REM 100/-7
    issue(3'd6, 32'hFFFF_FF9C, 32'd7,          5'd19, 32'hFFFF_FFFE, 1'b0, 1'b0); // REM -100/7
    issue(3'd5, 32'hFFFF_FFFF, 32'd1,          5'd20, 32'hFFFF_FFFF, 1'b0, 1'b0); // DIVU max/1

    // Flush mid-operation: no done, busy drops next cycle
    @(negedge clk);
    op = 3'd5; a = 32'd100; b = 32'd3; rd = 5'd4; start = 1'b1;
    t = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("flush_busy_before", {31'd0, busy}, 32'd1);
    while (cyc < t + 10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy_after", {31'd0, busy}, 32'd0);
    chk("flush_result_held", result, 32'hFFFF_FFFF);
    idle_cycles(40);

    // Flush and start together: flush wins
    @(negedge clk);
    op = 3'd5; a = 32'd100; b = 32'd3; rd = 5'd4; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", {31'd0, busy}, 32'd0);
    idle_cycles(40);

    // Reset mid-operation: everything cleared, no done
    @(negedge clk);
    op = 3'd5; a = 32'd100; b = 32'd3; rd = 5'd4; start = 1'b1;
    t = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < t + 10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst2_busy",   {31'd0, busy},  32'd0);
    chk("rst2_done",   {31'd0, done},  32'd0);
    chk("rst2_wb_we",  {31'd0, wb_we}, 32'd0);
    chk("rst2_result", result,         32'd0);
    chk("rst2_wb_rd",  {27'd0, wb_rd}, 32'd0);
    idle_cycles(40);

    // Recovery after reset
    issue(3'd5, 32'd100, 32'd3, 5'd4, 32'd33, 1'b0, 1'b0);
    idle_cycles(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish by 1ms");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have no parameters; the datapath is fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on the posedge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the clk posedge.
REQ-004 start  input  1  request a new operation; accepted only when busy=0.
REQ-005 op  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 a  input  32  rs1 operand from register-file read port 1, captured on start.
REQ-007 b  input  32  rs2 operand from register-file read port 2, captured on start.
REQ-008 rd  input  5  destination register index, captured on start.
REQ-009 flush  input  1  pipeline kill; aborts any in-flight operation.
REQ-010 busy  output  1  high while an operation is in flight (state != IDLE).
REQ-011 done  output  1  one-cycle pulse when result is valid.
REQ-012 result  output  32  operation result; held stable until the next accepted start.
REQ-013 wb_rd  output  5  captured rd, for register-file write address.
REQ-014 wb_we  output  1  register-file write enable: done AND (wb_rd != 0).

Function
REQ-015 States SHALL be IDLE, CALC, FIX, DONE; IDLE->CALC on accepted start (iterative path), CALC->FIX after 32 iterations, FIX->DONE, DONE->IDLE unconditionally.
REQ-016 Start accepted in cycle T SHALL capture a, b, op and rd, and load the 5-bit iteration counter with 0.
REQ-017 Division SHALL use radix-2 restoring, one quotient bit per CALC cycle on operand magnitudes; multiplication SHALL use shift-add, one multiplier bit per CALC cycle, 64-bit product.
REQ-018 FIX SHALL apply sign correction: quotient negated if signs differ, remainder takes the dividend sign, product negated per op signedness.
REQ-019 Result selection: MUL = product[31:0]; MULH/MULHSU/MULHU = product[63:32]; DIV/DIVU = quotient; REM/REMU = remainder.
REQ-020 Iterative latency: done SHALL be high exactly in cycle T+34.
REQ-021 Fast path (IDLE->DONE, done in T+1): divisor 0 -> DIV/DIVU 0xFFFFFFFF, REM/REMU = a; signed overflow a=0x80000000,b=0xFFFFFFFF -> DIV 0x80000000, REM 0.
REQ-022 start while busy=1 SHALL be ignored, with no change to captured operands.
REQ-023 flush SHALL force IDLE on the next edge with no done/wb_we pulse; flush and start in the same cycle -> flush wins, start dropped.
REQ-024 A new start SHALL be accepted no earlier than the cycle after done.
REQ-025 wb_rd and result SHALL remain stable from done until the next accepted start.

Reset
REQ-026 rst=1 at a posedge SHALL force state IDLE and busy=0, done=0, wb_we=0, result=0, wb_rd=0, counter=0, including mid-operation; no done is produced for the aborted operation.
REQ-027 rst SHALL take priority over flush and start.

Configuration
REQ-028 Macro MULDIV_FAST_MUL_EN: when defined, MUL/MULH/MULHSU/MULHU SHALL complete via the fast path (done in T+1) using a single-cycle 33x33 signed multiplier; when undefined, all multiplies SHALL be iterative (done in T+34).
REQ-029 Division latency and all other behaviour SHALL be identical with and without the macro.

Verification
REQ-030 DIV a=-7 (0xFFFFFFF9), b=2, rd=5 -> done at T+34, result 0xFFFFFFFD, wb_rd 5, wb_we 1.
REQ-031 REM a=-7, b=2 -> result 0xFFFFFFFF; REMU a=7, b=0 -> done at T+1, result 7; DIVU a=7, b=0 -> result 0xFFFFFFFF.
REQ-032 DIV a=0x80000000, b=0xFFFFFFFF -> done at T+1, result 0x80000000; REM -> 0.
REQ-033 MULH a=0x80000000, b=0x80000000 -> result 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; latency T+34 without the macro, T+1 with it.
REQ-034 MUL 3x4 with rd=0 -> result 12, done=1, wb_we=0; second start at T+5 while busy -> ignored, result still 12.
REQ-035 DIVU 100/3 with flush at T+10 -> busy=0 at T+11, no done; repeat with rst at T+10 -> all outputs 0 at T+11.
